cop0_unit: RTL and testbench

- Sequential System Control Coprocessor (CP0) for the multi-cycle reference CPU.
- Its inputs are the decoded COP0 operations MFC0, MTC0 and ERET, plus exception events from the datapath.
- Holds the architectural CP0 state and runs the Count/Compare timer.
- Computes the interrupt request and produces a registered redirect PC for exception entry and ERET.
- Parametrised over hardware interrupt lines, timer rate and exception vector.

---
 rtl/cop0_unit_if.sv | 41 ++++
 rtl/cop0_unit.sv | 215 +++++++++++++++++++++
 tb/tb_cop0_unit.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cop0_unit_if.sv
// cop0_unit_if: bus between the CPU control path and the CP0 unit.
//   MFC0 read port : rd_addr, rd_sel -> rd_data (combinational)
//   MTC0 write port: wr_en, wr_addr, wr_sel, wr_data
//   Exception port : exc_valid, exc_code, exc_pc, exc_bd, exc_badva_valid, exc_badva
//   ERET port      : eret_valid
//   Redirect       : redirect_valid (one-cycle pulse), redirect_pc
// modport master is the CPU side, modport slave is the CP0 side.
interface cop0_unit_if;
  logic [4:0]  rd_addr;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;

  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badva_valid;
  logic [31:0] exc_badva;

  logic        eret_valid;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output rd_addr, rd_sel, wr_en, wr_addr, wr_sel, wr_data,
           exc_valid, exc_code, exc_pc, exc_bd, exc_badva_valid, exc_badva, eret_valid,
    input  rd_data, redirect_valid, redirect_pc
  );

  modport slave (
    input  rd_addr, rd_sel, wr_en, wr_addr, wr_sel, wr_data,
           exc_valid, exc_code, exc_pc, exc_bd, exc_badva_valid, exc_badva, eret_valid,
    output rd_data, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cop0_unit.sv
// cop0_unit: System Control Coprocessor (CP0) for the multi-cycle CPU.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC, runs the Count/Compare
// timer, computes a registered interrupt request and emits a registered redirect
// pulse on exception entry and ERET.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   hw_int      : level-sensitive external interrupt lines (Cause.IP[2+i])
//   bus         : cop0_unit_if.slave (MFC0/MTC0/exception/ERET/redirect)
//   int_req     : take an interrupt at the next instruction boundary
//   status_exl  : Status.EXL
// Optional feature: define COP0_CONFIG_EN to make PRId(15,0) and Config(16,0)
// readable; otherwise they read 0 like every other unimplemented register.
module cop0_unit #(
  parameter int unsigned NUM_HW_INT = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_HW_INT-1:0] hw_int,
  cop0_unit_if.slave            bus,
  output logic                  int_req,
  output logic                  status_exl
);

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;
`ifdef COP0_CONFIG_EN
  localparam logic [4:0]  RegPrid    = 5'd15;
  localparam logic [4:0]  RegConfig  = 5'd16;
  localparam logic [31:0] PridVal    = 32'h00004220;
  localparam logic [31:0] ConfigVal  = 32'h80000000 | ((COUNT_DIV == 2) ? 32'h0 : 32'h8);
`endif

  localparam logic [3:0] DivMax = 4'(COUNT_DIV - 1);

  // Architectural state
  logic [31:0]           badvaddr_q, badvaddr_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           epc_q, epc_d;
  logic [7:0]            im_q, im_d;
  logic                  exl_q, exl_d;
  logic                  ie_q, ie_d;
  logic                  bd_q, bd_d;
  logic                  ti_q, ti_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [4:0]            exc_code_q, exc_code_d;
  // Timer prescaler and registered interrupt lines
  logic [3:0]            div_q, div_d;
  logic [NUM_HW_INT-1:0] hw_int_q, hw_int_d;
  // Registered outputs
  logic                  int_req_q, int_req_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [31:0]           redirect_pc_q, redirect_pc_d;

  logic [7:0]  cause_ip;
  logic [31:0] status_val;
  logic [31:0] cause_val;
  logic        tick;
  logic        wr_acc;

  // Cause.IP[7:0]: software bits, registered hw lines, and the timer folded into IP[7].
  always_comb begin
    cause_ip      = '0;
    cause_ip[1:0] = ip_sw_q;
    for (int i = 0; i < int'(NUM_HW_INT); i++) begin
      cause_ip[2+i] = hw_int_q[i];
    end
    cause_ip[7] = cause_ip[7] | ti_q;
  end

  assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_val  = {bd_q, ti_q, 14'b0, cause_ip, 1'b0, exc_code_q, 2'b0};

  // MFC0 read mux; reflects current state, so a same-cycle write is not visible yet.
  always_comb begin
    bus.rd_data = '0;
    if (bus.rd_sel == 3'd0) begin
      case (bus.rd_addr)
        RegBadVAddr: bus.rd_data = badvaddr_q;
        RegCount:    bus.rd_data = count_q;
        RegCompare:  bus.rd_data = compare_q;
        RegStatus:   bus.rd_data = status_val;
        RegCause:    bus.rd_data = cause_val;
        RegEpc:      bus.rd_data = epc_q;
`ifdef COP0_CONFIG_EN
        RegPrid:     bus.rd_data = PridVal;
        RegConfig:   bus.rd_data = ConfigVal;
`endif
        default:     bus.rd_data = '0;
      endcase
    end
  end

  // An MTC0 is accepted only when no exception or ERET commits in the same cycle.
  assign wr_acc = bus.wr_en & ~bus.exc_valid & ~bus.eret_valid & (bus.wr_sel == 3'd0);
  assign tick   = (div_q == DivMax);

  always_comb begin
    badvaddr_d       = badvaddr_q;
    count_d          = count_q;
    compare_d        = compare_q;
    epc_d            = epc_q;
    im_d             = im_q;
    exl_d            = exl_q;
    ie_d             = ie_q;
    bd_d             = bd_q;
    ti_d             = ti_q;
    ip_sw_d          = ip_sw_q;
    exc_code_d       = exc_code_q;
    hw_int_d         = hw_int;
    int_req_d        = ie_q & ~exl_q & (|(cause_ip & im_q));
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    // Free-running timer; TI latches on the increment that reaches Compare.
    div_d = tick ? 4'd0 : div_q + 4'd1;
    if (tick) begin
      count_d = count_q + 32'd1;
      if (count_q + 32'd1 == compare_q) begin
        ti_d = 1'b1;
      end
    end

    if (bus.exc_valid) begin
      exc_code_d = bus.exc_code;
      // A nested exception keeps the original return point.
      if (!exl_q) begin
        epc_d = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
        bd_d  = bus.exc_bd;
        exl_d = 1'b1;
      end
      if (bus.exc_badva_valid) begin
        badvaddr_d = bus.exc_badva;
      end
      redirect_valid_d = 1'b1;
      redirect_pc_d    = EXC_VECTOR;
    end else if (bus.eret_valid) begin
      exl_d            = 1'b0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = epc_q;
    end else if (wr_acc) begin
      case (bus.wr_addr)
        RegCount: begin
          // A Count load replaces this cycle's increment and restarts the prescaler.
          count_d = bus.wr_data;
          div_d   = 4'd0;
          ti_d    = ti_q;
        end
        RegCompare: begin
          compare_d = bus.wr_data;
          ti_d      = 1'b0;
        end
        RegStatus: begin
          im_d  = bus.wr_data[15:8];
          exl_d = bus.wr_data[1];
          ie_d  = bus.wr_data[0];
        end
        RegCause: ip_sw_d = bus.wr_data[9:8];
        RegEpc:   epc_d   = bus.wr_data;
        // BadVAddr is only loaded by exceptions.
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      badvaddr_q       <= '0;
      count_q          <= '0;
      compare_q        <= '0;
      epc_q            <= '0;
      im_q             <= '0;
      exl_q            <= 1'b0;
      ie_q             <= 1'b0;
      bd_q             <= 1'b0;
      ti_q             <= 1'b0;
      ip_sw_q          <= '0;
      exc_code_q       <= '0;
      div_q            <= '0;
      hw_int_q         <= '0;
      int_req_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      badvaddr_q       <= badvaddr_d;
      count_q          <= count_d;
      compare_q        <= compare_d;
      epc_q            <= epc_d;
      im_q             <= im_d;
      exl_q            <= exl_d;
      ie_q             <= ie_d;
      bd_q             <= bd_d;
      ti_q             <= ti_d;
      ip_sw_q          <= ip_sw_d;
      exc_code_q       <= exc_code_d;
      div_q            <= div_d;
      hw_int_q         <= hw_int_d;
      int_req_q        <= int_req_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign int_req            = int_req_q;
  assign status_exl         = exl_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_cop0_unit.sv
// tb_cop0_unit: directed test-plan sequences plus randomized traffic for cop0_unit,
// checked against an architectural register model kept in the bench.
module tb_cop0_unit;
  localparam int unsigned NumHwInt  = 6;
  localparam int unsigned CountDiv  = 2;
  localparam logic [31:0] ExcVector = 32'hbfc00380;

  logic                clk = 1'b0;
  logic                reset;
  logic [NumHwInt-1:0] hw_int;
  logic                int_req;
  logic                status_exl;

  cop0_unit_if bus ();

  cop0_unit #(
    .NUM_HW_INT(NumHwInt),
    .COUNT_DIV (CountDiv),
    .EXC_VECTOR(ExcVector)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hw_int    (hw_int),
    .bus       (bus.slave),
    .int_req   (int_req),
    .status_exl(status_exl)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (architectural view) ----------------
  logic [31:0]         m_count_base;
  longint unsigned     m_elapsed;     // cycles since Count was last loaded
  logic [31:0]         m_compare, m_status, m_epc, m_badva, m_redir_pc;
  logic [1:0]          m_ip_sw;
  logic                m_ti, m_bd, m_int_req, m_redir_v;
  logic [4:0]          m_exc_code;
  logic [NumHwInt-1:0] m_hw_d;

  function automatic logic [31:0] m_count();
    return m_count_base + 32'(m_elapsed / longint'(CountDiv));
  endfunction

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c = 32'(m_ip_sw) << 8;
    c = c | (32'(m_hw_d) << 10);
    c = c | (32'(m_ti) << 15) | (32'(m_ti) << 30) | (32'(m_bd) << 31);
    c = c | (32'(m_exc_code) << 2);
    return c;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] addr, input logic [2:0] sel);
    if (sel != 3'd0) return 32'h0;
    case (addr)
      5'd8:    return m_badva;
      5'd9:    return m_count();
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
`ifdef COP0_CONFIG_EN
      5'd15:   return 32'h00004220;
      5'd16:   return (CountDiv == 2) ? 32'h80000000 : 32'h80000008;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_count_base = '0; m_elapsed = 0; m_compare = '0; m_status = 32'h00400000;
    m_epc = '0; m_badva = '0; m_redir_pc = '0; m_ip_sw = '0; m_ti = 1'b0; m_bd = 1'b0;
    m_int_req = 1'b0; m_redir_v = 1'b0; m_exc_code = '0; m_hw_d = '0;
  endtask

  // One clock edge of architectural behaviour, using the inputs currently driven.
  task automatic model_step();
    logic [31:0] cause, old_cnt, new_cnt;
    logic        nxt_int, exc, eret, wr;
    cause   = m_cause();
    nxt_int = m_status[0] & ~m_status[1] & (|(cause[15:8] & m_status[15:8]));
    exc     = bus.exc_valid;
    eret    = bus.eret_valid && !exc;
    wr      = bus.wr_en && !exc && !eret && (bus.wr_sel == 3'd0);
    m_redir_v = exc || eret;
    if (exc) m_redir_pc = ExcVector;
    else if (eret) m_redir_pc = m_epc;
    if (!(wr && bus.wr_addr == 5'd9)) begin
      old_cnt = m_count();
      m_elapsed++;
      new_cnt = m_count();
      if (new_cnt != old_cnt && new_cnt == m_compare) m_ti = 1'b1;
    end
    if (exc) begin
      m_exc_code = bus.exc_code;
      if (!m_status[1]) begin
        m_epc      = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
        m_bd       = bus.exc_bd;
        m_status[1] = 1'b1;
      end
      if (bus.exc_badva_valid) m_badva = bus.exc_badva;
    end else if (eret) begin
      m_status[1] = 1'b0;
    end else if (wr) begin
      case (bus.wr_addr)
        5'd9:  begin m_count_base = bus.wr_data; m_elapsed = 0; end
        5'd11: begin m_compare = bus.wr_data; m_ti = 1'b0; end
        5'd12: m_status = 32'h00400000 | (bus.wr_data & 32'h0000ff03);
        5'd13: m_ip_sw = bus.wr_data[9:8];
        5'd14: m_epc = bus.wr_data;
        default: ;
      endcase
    end
    m_hw_d    = hw_int;
    m_int_req = nxt_int;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.wr_en = 1'b0; bus.exc_valid = 1'b0; bus.eret_valid = 1'b0;
    bus.exc_badva_valid = 1'b0; bus.exc_bd = 1'b0;
    bus.wr_sel = 3'd0; bus.rd_sel = 3'd0;
  endtask

  task automatic check_outputs();
    check_eq($sformatf("rd_data[%0d,%0d]", bus.rd_addr, bus.rd_sel), bus.rd_data,
             m_read(bus.rd_addr, bus.rd_sel));
    check_eq("int_req", 32'(int_req), 32'(m_int_req));
    check_eq("status_exl", 32'(status_exl), 32'(m_status[1]));
    check_eq("redirect_valid", 32'(bus.redirect_valid), 32'(m_redir_v));
    if (m_redir_v) check_eq("redirect_pc", bus.redirect_pc, m_redir_pc);
  endtask

  // Called just after a negedge with inputs set: check, cross one posedge, return at negedge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_sel = 3'd0; bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.rd_addr = addr; bus.rd_sel = 3'd0;
    #1;
    check_eq(tag, bus.rd_data, exp);
  endtask

  task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic bv, input logic [31:0] va);
    bus.exc_valid = 1'b1; bus.exc_code = code; bus.exc_pc = pc; bus.exc_bd = bd;
    bus.exc_badva_valid = bv; bus.exc_badva = va;
    tick();
    bus.exc_valid = 1'b0; bus.exc_badva_valid = 1'b0; bus.exc_bd = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_rst;
    hw_int = '0;
    bus.rd_addr = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.exc_code = '0; bus.exc_pc = '0; bus.exc_badva = '0;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state: every register while reset is held.
    for (int a = 0; a < 32; a++) begin
      exp_rst = 32'h0;
      if (a == 12) exp_rst = 32'h00400000;
`ifdef COP0_CONFIG_EN
      if (a == 15) exp_rst = 32'h00004220;
      if (a == 16) exp_rst = (CountDiv == 2) ? 32'h80000000 : 32'h80000008;
`endif
      peek($sformatf("reset_reg%0d", a), 5'(a), exp_rst);
    end
    check_eq("reset_redirect_valid", 32'(bus.redirect_valid), 32'h0);
    check_eq("reset_redirect_pc", bus.redirect_pc, 32'h0);
    check_eq("reset_int_req", 32'(int_req), 32'h0);

    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Timer: Compare = 5, ten cycles from reset release.
    mtc0(5'd11, 32'd5);
    repeat (9) tick();
    peek("count_after_10", 5'd9, 32'd5);
    peek("cause_ti_set", 5'd13, 32'h40008000);
    mtc0(5'd12, 32'h00008001);
    tick();
    check_eq("int_req_timer", 32'(int_req), 32'h1);
    mtc0(5'd11, 32'd100);
    peek("cause_ti_clear", 5'd13, 32'h0);
    tick();
    check_eq("int_req_timer_drop", 32'(int_req), 32'h0);

    // Exception entry from a delay slot.
    raise_exc(5'd4, 32'hbfc00100, 1'b1, 1'b1, 32'h1235);
    peek("epc_bd", 5'd14, 32'hbfc000fc);
    peek("cause_bd_code", 5'd13, 32'h80000010);
    peek("badvaddr", 5'd8, 32'h1235);
    check_eq("exc_exl", 32'(status_exl), 32'h1);
    check_eq("exc_redirect_valid", 32'(bus.redirect_valid), 32'h1);
    check_eq("exc_redirect_pc", bus.redirect_pc, 32'hbfc00380);

    // Nested exception keeps EPC, updates ExcCode; then ERET returns to first EPC.
    raise_exc(5'd5, 32'h80000000, 1'b0, 1'b0, 32'h0);
    peek("nested_epc", 5'd14, 32'hbfc000fc);
    peek("nested_cause", 5'd13, 32'h80000014);
    bus.eret_valid = 1'b1;
    tick();
    bus.eret_valid = 1'b0;
    check_eq("eret_redirect_pc", bus.redirect_pc, 32'hbfc000fc);
    check_eq("eret_redirect_valid", 32'(bus.redirect_valid), 32'h1);
    check_eq("eret_exl", 32'(status_exl), 32'h0);
    tick();
    check_eq("redirect_one_cycle", 32'(bus.redirect_valid), 32'h0);

    // Exception, ERET and MTC0 Status together: only the exception lands.
    bus.eret_valid = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h0;
    raise_exc(5'd2, 32'h00000100, 1'b0, 1'b0, 32'h0);
    bus.eret_valid = 1'b0; bus.wr_en = 1'b0;
    peek("coincide_status", 5'd12, 32'h00408003);
    peek("coincide_epc", 5'd14, 32'h00000100);
    check_eq("coincide_redirect_pc", bus.redirect_pc, 32'hbfc00380);
    bus.eret_valid = 1'b1;
    tick();
    bus.eret_valid = 1'b0;

    // Hardware interrupt line 0.
    mtc0(5'd12, 32'h00000401);
    hw_int = 6'b000001;
    tick();
    peek("cause_ip2", 5'd13, 32'h00000408);
    check_eq("hw_int_req_1cyc", 32'(int_req), 32'h0);
    tick();
    check_eq("hw_int_req_2cyc", 32'(int_req), 32'h1);
    mtc0(5'd12, 32'h00000403);
    tick();
    check_eq("hw_int_req_exl", 32'(int_req), 32'h0);
`ifdef COP0_CONFIG_EN
    peek("prid", 5'd15, 32'h00004220);
`else
    peek("prid_absent", 5'd15, 32'h0);
`endif
    hw_int = '0;
    mtc0(5'd12, 32'h0);

    // Randomized traffic against the model, with one mid-run asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      idle();
      bus.rd_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(8, 16));
      bus.rd_sel  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0;
      if ($urandom_range(0, 7) == 0) hw_int = NumHwInt'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0;
        bus.wr_addr = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(8, 14));
        bus.wr_data = $urandom;
        if (bus.wr_addr == 5'd11 && $urandom_range(0, 1) == 0)
          bus.wr_data = m_count() + 32'($urandom_range(1, 6));
      end
      if ($urandom_range(0, 15) == 0) begin
        bus.exc_valid = 1'b1; bus.exc_code = 5'($urandom); bus.exc_pc = $urandom;
        bus.exc_bd = 1'($urandom); bus.exc_badva_valid = 1'($urandom);
        bus.exc_badva = $urandom;
      end
      if ($urandom_range(0, 15) == 0) bus.eret_valid = 1'b1;

      if (n == 1500) begin
        bus.exc_valid = 1'b1;
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        #2 reset = 1'b1;
        #1;
        check_eq("midreset_redirect_valid", 32'(bus.redirect_valid), 32'h0);
        check_eq("midreset_exl", 32'(status_exl), 32'h0);
        model_reset();
        idle();
        @(negedge clk);
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
